// File: rtl/prog_loader_pkg.sv
// Shared instruction-format definitions for the program loader:
// loader state encodings, instruction field positions, the reserved-bit
// mask applied to the high byte of each word, and the opcode values.
package prog_loader_pkg;

    // Loader state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHK   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_e;

    // Instruction word field positions (16-bit word)
    localparam int WORD_W     = 16;
    localparam int F_RSVD_MSB = 15;
    localparam int F_RSVD_LSB = 14;
    localparam int F_R1_BIT   = 13;
    localparam int F_R0_BIT   = 12;
    localparam int F_OP_MSB   = 11;
    localparam int F_OP_LSB   = 8;
    localparam int F_DATA_MSB = 7;
    localparam int F_DATA_LSB = 0;

    // Reserved field as seen in the high byte of the stream ([7:6])
    localparam logic [7:0] HI_RSVD_MASK = 8'hC0;

    // Opcode values carried in bits [11:8]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    // True for states in which a stream byte may be consumed
    function automatic logic is_accepting(input state_e s);
        return (s == ST_LEN) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHK);
    endfunction

    // True for states that count as an active load
    function automatic logic is_busy(input state_e s);
        return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR));
    endfunction

    // A high byte is legal only when its reserved bits are clear
    function automatic logic hi_byte_legal(input logic [7:0] b);
        return (b & HI_RSVD_MASK) == 8'h00;
    endfunction

    // Assemble the instruction word from its two stream bytes
    function automatic logic [WORD_W-1:0] pack_word(input logic [7:0] hi,
                                                    input logic [7:0] lo);
        logic [WORD_W-1:0] w;
        w = '0;
        w[F_RSVD_MSB:F_RSVD_LSB] = hi[7:6];
        w[F_R1_BIT]              = hi[5];
        w[F_R0_BIT]              = hi[4];
        w[F_OP_MSB:F_OP_LSB]     = hi[3:0];
        w[F_DATA_MSB:F_DATA_LSB] = lo;
        return w;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader. Consumes a length byte, N two-byte
// instruction words and an XOR checksum byte, writing each word into
// program memory as soon as its low byte arrives. All outputs are
// registered; they are computed from the next state on every edge.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Index counter is wide enough to compare against the 8-bit length byte
    localparam int CNT_W = (ADDR_W > 8) ? ADDR_W : 8;

    state_e             state_q, state_d;
    logic [7:0]         n_q, n_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [7:0]         csum_q, csum_d;
    logic [7:0]         hi_q, hi_d;

    logic               byte_ready_q, byte_ready_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [15:0]        mem_wdata_q, mem_wdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic [CNT_W-1:0]   idx_inc;

    assign accept  = byte_valid & byte_ready_q;
    assign idx_inc = idx_q + 1'b1;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        hi_d        = hi_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE, ST_ERR: begin
                // A fresh load restarts the word index and checksum
                if (start) begin
                    state_d = ST_LEN;
                    idx_d   = '0;
                    csum_d  = 8'h00;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (byte_in == 8'h00) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = byte_in;
                        state_d = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (accept) begin
                    if (!hi_byte_legal(byte_in)) begin
                        state_d = ST_ERR;
                    end else begin
                        hi_d    = byte_in;
                        csum_d  = csum_q ^ byte_in;
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                // Write strobe is raised on this edge so it is seen
                // during the single WRITE cycle
                if (accept) begin
                    csum_d      = csum_q ^ byte_in;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = idx_q[ADDR_W-1:0];
                    mem_wdata_d = pack_word(hi_q, byte_in);
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == CNT_W'(n_q)) ? ST_CHK : ST_HI;
            end
            ST_CHK: begin
                if (accept) begin
                    state_d = (byte_in == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        byte_ready_d = is_accepting(state_d);
        busy_d       = is_busy(state_d);
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERR);
    end

    // State, counters and registered outputs; reset clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            n_q          <= 8'h00;
            idx_q        <= '0;
            csum_q       <= 8'h00;
            hi_q         <= 8'h00;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 16'h0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            hi_q         <= hi_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed streams plus randomized
// loads with byte gaps and spurious start pulses, checked against a
// stream-level reference model.
module tb_prog_loader;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model results
    int          m_consumed;
    bit          m_ok;
    int          m_wr_addr[$];
    int          m_wr_data[$];

    // Writes the monitor still expects to see
    int          exp_addr[$];
    int          exp_data[$];

    bit          gaps_en;
    bit          drv_done_byte;
    bit          acc_chk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Stream-level model: walk the bytes by the format rules
    function automatic void run_model(input logic [7:0] s[$]);
        int p;
        int n;
        logic [7:0] x;
        logic [7:0] hi;
        m_wr_addr.delete();
        m_wr_data.delete();
        m_ok = 1'b0;
        x = 8'h00;
        n = s[0];
        p = 1;
        if (n == 0) begin
            m_consumed = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            hi = s[p];
            p++;
            if (hi[7:6] != 2'b00) begin
                m_consumed = p;
                return;
            end
            m_wr_addr.push_back(i);
            m_wr_data.push_back({hi, s[p]});
            x = x ^ hi ^ s[p];
            p++;
        end
        m_consumed = p + 1;
        m_ok = (s[p] == x);
    endfunction

    // Registers whether a successful checksum byte was taken on this edge
    always @(posedge clk or posedge rst) begin
        if (rst) acc_chk <= 1'b0;
        else     acc_chk <= byte_valid && byte_ready && drv_done_byte;
    end

    // Per-cycle compare of done and memory writes against expectations
    always @(negedge clk) begin
        if (!rst) begin
            check("done_timing", done, acc_chk);
            if (mem_we) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_mem_we", 1, 0);
                end else begin
                    check("mem_addr", mem_addr, exp_addr.pop_front());
                    check("mem_wdata", mem_wdata, exp_data.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last_ok);
        int gap;
        bit taken;
        gap = gaps_en ? $urandom_range(0, 3) : 0;
        repeat (gap) begin
            byte_valid = 1'b0;
            start = gaps_en && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_in = b;
        drv_done_byte = last_ok;
        start = gaps_en && ($urandom_range(0, 3) == 0);
        taken = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (byte_ready) begin
                @(negedge clk);
                taken = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!taken) check("byte_accept_timeout", 0, 1);
        byte_valid = 1'b0;
        drv_done_byte = 1'b0;
        start = 1'b0;
    endtask

    task automatic start_load();
        start = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_after_start", err, 0);
    endtask

    // Full load: model, start, drive the consumed bytes, check outcome
    task automatic do_load(input logic [7:0] s[$]);
        run_model(s);
        foreach (m_wr_addr[i]) begin
            exp_addr.push_back(m_wr_addr[i]);
            exp_data.push_back(m_wr_data[i]);
        end
        start_load();
        for (int i = 0; i < m_consumed; i++)
            send_byte(s[i], (i == m_consumed - 1) && m_ok);
        repeat (3) @(negedge clk);
        check("err_outcome", err, !m_ok);
        check("busy_idle", busy, 0);
        check("ready_low", byte_ready, 0);
        check("writes_drained", exp_addr.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        int n;
        logic [7:0] x;
        logic [7:0] hi;
        logic [7:0] lo;

        rst = 1'b1;
        start = 1'b0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        gaps_en = 1'b0;
        drv_done_byte = 1'b0;
        #1;
        check("rst_ready", byte_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Two-word load
        s = '{8'h02, 8'h01, 8'h05, 8'h02, 8'h07, 8'h01};
        run_model(s);
        check("pin_ok_a", m_ok, 1);
        check("pin_cnt_a", m_wr_data.size(), 2);
        check("pin_w0_a", m_wr_data[0], 32'h0105);
        check("pin_w1_a", m_wr_data[1], 32'h0207);
        do_load(s);

        // Zero length
        s = '{8'h00};
        run_model(s);
        check("pin_ok_b", m_ok, 0);
        check("pin_cons_b", m_consumed, 1);
        do_load(s);

        // Reserved bits set in high byte
        s = '{8'h01, 8'h41, 8'h00, 8'h41};
        run_model(s);
        check("pin_cons_c", m_consumed, 2);
        check("pin_cnt_c", m_wr_data.size(), 0);
        do_load(s);

        // Bad checksum after one written word
        s = '{8'h01, 8'h02, 8'h03, 8'h00};
        run_model(s);
        check("pin_ok_d", m_ok, 0);
        check("pin_w0_d", m_wr_data[0], 32'h0203);
        do_load(s);

        // Reset in the middle of a load
        exp_addr.push_back(0);
        exp_data.push_back(32'h31AA);
        start_load();
        send_byte(8'h02, 1'b0);
        send_byte(8'h31, 1'b0);
        send_byte(8'hAA, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", byte_ready, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_writes", exp_addr.size(), 0);
        @(negedge clk);

        s = '{8'h01, 8'h00, 8'h10, 8'h10};
        run_model(s);
        check("pin_w0_e", m_wr_data[0], 32'h0010);
        do_load(s);

        // Randomized loads with gaps and spurious starts
        gaps_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            s.delete();
            n = $urandom_range(1, 6);
            s.push_back(n[7:0]);
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                hi = 8'($urandom_range(0, 63));
                if ($urandom_range(0, 19) == 0) hi[7:6] = 2'($urandom_range(1, 3));
                lo = 8'($urandom);
                x = x ^ hi ^ lo;
                s.push_back(hi);
                s.push_back(lo);
            end
            if ($urandom_range(0, 4) == 0) x = x ^ 8'($urandom_range(1, 255));
            s.push_back(x);
            do_load(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, program memory address width; max program length 2^ADDR_W - 1 words.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a load; ignored unless in IDLE.
REQ-005 byte_in  input  8  incoming stream byte.
REQ-006 byte_valid  input  1  byte_in holds a valid byte.
REQ-007 byte_ready  output  1  loader can accept a byte this cycle.
REQ-008 mem_we  output  1  program memory write strobe, one cycle per word.
REQ-009 mem_addr  output  ADDR_W  program memory word address.
REQ-010 mem_wdata  output  16  instruction word: [15:14] reserved, [13] R1 select, [12] R0 select, [11:8] opcode, [7:0] data.
REQ-011 busy  output  1  high in every state except IDLE, DONE, ERR.
REQ-012 done  output  1  one-cycle pulse on successful load.
REQ-013 err  output  1  held high after a failed load until next accepted start.

Function
REQ-014 A byte SHALL be accepted on a rising edge where byte_valid and byte_ready are both high; no other byte is consumed.
REQ-015 Stream format SHALL be: length byte N, then N words each as high byte then low byte, then one checksum byte.
REQ-016 byte_ready SHALL be high only in states LEN, HI, LO, CHK.
REQ-017 States: IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR; reset state IDLE.
REQ-018 IDLE -> LEN on start; err cleared and word index and checksum zeroed on the same edge.
REQ-019 LEN: accepted N=0 -> ERR; N>0 -> HI, N stored.
REQ-020 HI: accepted byte with bits [7:6] nonzero -> ERR (reserved field violation); otherwise stored, -> LO.
REQ-021 LO: accepted byte stored, -> WRITE.
REQ-022 WRITE lasts exactly one cycle: mem_we=1, mem_addr=word index, mem_wdata={high,low}; then index increments; -> CHK if new index equals N, else HI.
REQ-023 Latency: mem_we asserted in the cycle immediately after the low byte is accepted.
REQ-024 Checksum SHALL be the 8-bit XOR of all accepted word bytes (length and checksum bytes excluded).
REQ-025 CHK: accepted byte equal to running checksum -> DONE; mismatch -> ERR.
REQ-026 DONE lasts one cycle with done=1, then -> IDLE.
REQ-027 ERR: err=1, no writes, byte_ready=0; -> LEN on start (err cleared on that edge).
REQ-028 Words already written before an error SHALL remain written; no rollback.
REQ-029 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata SHALL hold last values outside WRITE.
REQ-030 start while busy SHALL have no effect.
REQ-031 byte_valid low in any accepting state SHALL stall indefinitely with no state change.

Reset
REQ-032 rst asserted SHALL force, without waiting for clk: state IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, index, N and checksum 0.
REQ-033 rst mid-load SHALL abort with no further mem_we; memory contents untouched by the loader.
REQ-034 First accepted start after rst release SHALL behave as from power-up.

Structure
REQ-035 State encodings, reserved-bit mask (high byte [7:6]) and field positions SHALL live in the shared instruction include file alongside the opcode defines.
REQ-036 Single module, no sub-modules; one state register, one index counter, one checksum register.

Verification
REQ-037 start, stream 02,01,05,02,07,checksum 01 -> mem_we twice: addr0=0x0105, addr1=0x0207; done pulse one cycle after checksum accepted; err=0.
REQ-038 start, length 00 -> ERR, err=1, no mem_we, byte_ready=0.
REQ-039 start, 01, high byte 0x41 -> ERR immediately, no mem_we; next start clears err.
REQ-040 start, 01,02,03, checksum 00 (expected 01) -> addr0=0x0203 written, then err=1, done never pulses.
REQ-041 start, 02,31,AA then rst for one cycle -> one write only (addr0=0x31AA), all outputs reset immediately; new load 01,00,10,10 succeeds at addr0=0x0010.
REQ-042 Random byte_valid gaps and start pulses while busy -> memory contents and done timing identical to gap-free run.
